// File: rtl/ibuf_rd_seq.sv
// Burst read sequencer for instruction buffer port a: one descriptor at a time, credit-limited reads.
// Optional feature macro IBUF_RD_STRIDE_EN: per-beat address increment taken from cmd_stride.
module ibuf_rd_seq #(
  parameter int ADDR_W    = 15,
  parameter int LEN_W     = 12,
  parameter int DATA_W    = 128,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_stride,
  output logic              ib_cen,
  output logic              ib_wen,
  output logic [ADDR_W-1:0] ib_addr,
  output logic              ib_last,
  input  logic              ib_ready,
  input  logic [DATA_W-1:0] ib_rdata,
  input  logic              ib_rvalid,
  input  logic              ib_rlast,
  output logic              ib_rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int NUM_BANKS = 24;
  localparam int BANK_WORDS = 1024;
  localparam logic [ADDR_W:0] WRAP = (ADDR_W + 1)'(NUM_BANKS * BANK_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  outst_next;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] addr_next;
  logic              bank_ok;
  logic              issue;
  logic              ret;

  // Any start address at or beyond bank 24 has no backing storage.
  assign bank_ok = ({1'b0, cmd_addr} < WRAP);

`ifdef IBUF_RD_STRIDE_EN
  logic [ADDR_W-1:0] stride;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride <= '0;
    end else if (cmd_valid && cmd_ready && bank_ok) begin
      stride <= cmd_stride;
    end
  end

  assign step = stride;
`else
  logic unused_stride;
  assign unused_stride = ^cmd_stride;
  assign step = ADDR_W'(1);
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign ib_wen    = 1'b0;
  assign ib_addr   = addr;
  assign ib_cen    = (state == ISSUE) && (outst < CNT_W'(MAX_OUTST));
  assign ib_last   = (state == ISSUE) && (remaining == '0);

  assign out_data  = ib_rdata;
  assign out_valid = ib_rvalid;
  assign out_last  = ib_rlast;
  assign ib_rready = out_ready;

  assign issue = ib_cen && ib_ready;
  assign ret   = ib_rvalid && ib_rready && (outst != '0);

  // Sum is one bit wider so crossing 24576 is detectable before wrapping to bank 0.
  assign addr_sum  = {1'b0, addr} + {1'b0, step};
  assign addr_next = ADDR_W'((addr_sum >= WRAP) ? (addr_sum - WRAP) : addr_sum);

  always_comb begin
    outst_next = outst;
    case ({issue, ret})
      2'b10:   outst_next = outst + CNT_W'(1);
      2'b01:   outst_next = outst - CNT_W'(1);
      default: outst_next = outst;
    endcase
  end

  // done is raised once the last return lands and held a single cycle before IDLE reopens cmd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      outst     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      outst <= outst_next;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (bank_ok) begin
              addr      <= cmd_addr;
              remaining <= cmd_len;
              state     <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr      <= addr_next;
            remaining <= remaining - LEN_W'(1);
            if (ib_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
          end else if (outst_next == '0) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_outst_max: assert property (@(posedge clk) disable iff (!rst_n)
    outst <= CNT_W'(MAX_OUTST));

  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ib_cen && !ib_ready) |=> (ib_cen && $stable(ib_addr) && $stable(ib_last)));

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && err));
`endif

endmodule

// File: tb/tb_ibuf_rd_seq.sv
// Directed self-checking bench for ibuf_rd_seq with a 2-cycle-latency buffer model.
`timescale 1ns/1ps
module tb_ibuf_rd_seq;

  localparam int ADDR_W    = 15;
  localparam int LEN_W     = 12;
  localparam int DATA_W    = 128;
  localparam int MAX_OUTST = 4;
  localparam int LOG_N     = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_stride;
  logic              ib_cen;
  logic              ib_wen;
  logic [ADDR_W-1:0] ib_addr;
  logic              ib_last;
  logic              ib_ready;
  logic [DATA_W-1:0] ib_rdata = '0;
  logic              ib_rvalid = 1'b0;
  logic              ib_rlast = 1'b0;
  logic              ib_rready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;

  ibuf_rd_seq #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .ib_cen(ib_cen), .ib_wen(ib_wen), .ib_addr(ib_addr), .ib_last(ib_last),
    .ib_ready(ib_ready), .ib_rdata(ib_rdata), .ib_rvalid(ib_rvalid),
    .ib_rlast(ib_rlast), .ib_rready(ib_rready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic              l;
    int                rdy;
  } beat_t;
  beat_t bq[$];

  logic [ADDR_W-1:0] req_addr[LOG_N];
  logic              req_last[LOG_N];
  int                req_cyc[LOG_N];
  int                req_n = 0;
  logic [DATA_W-1:0] out_data_log[LOG_N];
  logic              out_last_log[LOG_N];
  int                out_cyc[LOG_N];
  int                out_n = 0;
  int                acc_cyc = 0;
  int                done_n = 0;
  int                done_cyc = 0;
  logic              done_rdy = 1'b0;
  int                err_n = 0;
  int                err_cyc = 0;
  logic [ADDR_W-1:0] exp_a[8];

  function automatic logic [DATA_W-1:0] makeData(input logic [ADDR_W-1:0] a);
    return {8{1'b0, a}};
  endfunction

  // Monitor logs handshakes at the edge; buffer model returns data two edges after a request.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (ib_rvalid && ib_rready) begin
        if (out_n < LOG_N) begin
          out_data_log[out_n] = out_data;
          out_last_log[out_n] = out_last;
          out_cyc[out_n] = cyc;
        end
        out_n++;
        if (bq.size() > 0) void'(bq.pop_front());
      end
      if (ib_cen && ib_ready) begin
        if (req_n < LOG_N) begin
          req_addr[req_n] = ib_addr;
          req_last[req_n] = ib_last;
          req_cyc[req_n] = cyc;
        end
        req_n++;
        bq.push_back('{a: ib_addr, l: ib_last, rdy: cyc + 1});
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
        done_rdy = cmd_ready;
      end
      if (err) begin
        err_n++;
        err_cyc = cyc;
      end
    end
    #1;
    if (!rst_n) bq.delete();
    if (bq.size() > 0 && bq[0].rdy <= cyc) begin
      ib_rvalid = 1'b1;
      ib_rdata  = makeData(bq[0].a);
      ib_rlast  = bq[0].l;
    end else begin
      ib_rvalid = 1'b0;
      ib_rdata  = '0;
      ib_rlast  = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                               input logic [ADDR_W-1:0] stride);
    @(negedge clk);
    cmd_addr   = a;
    cmd_len    = len;
    cmd_stride = stride;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int start;
    int i;
    start = done_n;
    i = 0;
    while (done_n == start && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (done_n == start) checkOutput({tag, "_timeout"}, 128'(done_n - start), 128'(1));
  endtask

  task automatic checkBurst(input string tag, input int rb, input int ob, input int beats);
    checkOutput({tag, "_nreq"}, 128'(req_n - rb), 128'(beats));
    checkOutput({tag, "_nout"}, 128'(out_n - ob), 128'(beats));
    for (int i = 0; i < beats; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 128'(req_addr[rb + i]), 128'(exp_a[i]));
      checkOutput($sformatf("%s_last%0d", tag, i), 128'(req_last[rb + i]), 128'(i == beats - 1));
      checkOutput($sformatf("%s_data%0d", tag, i), out_data_log[ob + i], makeData(exp_a[i]));
      checkOutput($sformatf("%s_olast%0d", tag, i), 128'(out_last_log[ob + i]),
                  128'(i == beats - 1));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rb, ob, dn, eb;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_stride = '0;
    ib_ready   = 1'b1;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_cen", 128'(ib_cen), 128'(0));
    checkOutput("rst_last", 128'(ib_last), 128'(0));
    checkOutput("rst_addr", 128'(ib_addr), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));
    checkOutput("rst_cmdrdy", 128'(cmd_ready), 128'(1));
    checkOutput("rst_wen", 128'(ib_wen), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat: request T+1, data T+3, done T+4, cmd_ready back T+5.
    rb = req_n; ob = out_n; dn = done_n;
    applyStimulus(15'h0123, 12'd0, 15'd0);
    waitDone("t1", 50);
    checkOutput("t1_cmdrdy_after", 128'(cmd_ready), 128'(1));
    checkOutput("t1_busy_after", 128'(busy), 128'(0));
    checkOutput("t1_req_cyc", 128'(req_cyc[rb] - acc_cyc), 128'(1));
    checkOutput("t1_out_cyc", 128'(out_cyc[ob] - acc_cyc), 128'(3));
    checkOutput("t1_done_cyc", 128'(done_cyc - acc_cyc), 128'(4));
    checkOutput("t1_done_cmdrdy", 128'(done_rdy), 128'(0));
    exp_a[0] = 15'h0123;
    repeat (3) @(negedge clk);
    checkBurst("t1", rb, ob, 1);
    checkOutput("t1_ndone", 128'(done_n - dn), 128'(1));

    // Eight beats, full throughput.
    rb = req_n; ob = out_n; dn = done_n;
    applyStimulus(15'h0100, 12'd7, 15'd0);
    waitDone("t2", 100);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) exp_a[i] = 15'h0100 + 15'(i);
    checkBurst("t2", rb, ob, 8);
    checkOutput("t2_back2back", 128'(req_cyc[rb + 7] - req_cyc[rb]), 128'(7));
    checkOutput("t2_ndone", 128'(done_n - dn), 128'(1));

    // Consumer stalled: credits saturate at MAX_OUTST, then drain without loss.
    rb = req_n; ob = out_n; dn = done_n;
    out_ready = 1'b0;
    applyStimulus(15'h0100, 12'd7, 15'd0);
    repeat (10) @(negedge clk);
    checkOutput("t3_sat_nreq", 128'(req_n - rb), 128'(MAX_OUTST));
    checkOutput("t3_sat_cen", 128'(ib_cen), 128'(0));
    checkOutput("t3_sat_nout", 128'(out_n - ob), 128'(0));
    checkOutput("t3_sat_busy", 128'(busy), 128'(1));
    out_ready = 1'b1;
    waitDone("t3", 200);
    repeat (3) @(negedge clk);
    checkBurst("t3", rb, ob, 8);
    checkOutput("t3_ndone", 128'(done_n - dn), 128'(1));

    // Wrap past bank 23, with the buffer stalling the first request.
    rb = req_n; ob = out_n; dn = done_n;
    ib_ready = 1'b0;
    applyStimulus(15'h5FFE, 12'd2, 15'd0);
    checkOutput("t4_stall_cen0", 128'(ib_cen), 128'(1));
    checkOutput("t4_stall_addr0", 128'(ib_addr), 128'(15'h5FFE));
    checkOutput("t4_stall_last0", 128'(ib_last), 128'(0));
    repeat (2) @(negedge clk);
    checkOutput("t4_stall_cen1", 128'(ib_cen), 128'(1));
    checkOutput("t4_stall_addr1", 128'(ib_addr), 128'(15'h5FFE));
    checkOutput("t4_stall_last1", 128'(ib_last), 128'(0));
    ib_ready = 1'b1;
    waitDone("t4", 100);
    repeat (3) @(negedge clk);
    exp_a[0] = 15'h5FFE; exp_a[1] = 15'h5FFF; exp_a[2] = 15'h0000;
    checkBurst("t4", rb, ob, 3);
    checkOutput("t4_ndone", 128'(done_n - dn), 128'(1));

    // Illegal start bank.
    rb = req_n; eb = err_n; dn = done_n;
    applyStimulus(15'h6000, 12'd3, 15'd0);
    checkOutput("t5_err_pulse", 128'(err), 128'(1));
    checkOutput("t5_busy", 128'(busy), 128'(0));
    checkOutput("t5_cmdrdy", 128'(cmd_ready), 128'(1));
    checkOutput("t5_cen", 128'(ib_cen), 128'(0));
    @(negedge clk);
    checkOutput("t5_err_clear", 128'(err), 128'(0));
    repeat (4) @(negedge clk);
    checkOutput("t5_nreq", 128'(req_n - rb), 128'(0));
    checkOutput("t5_nerr", 128'(err_n - eb), 128'(1));
    checkOutput("t5_err_cyc", 128'(err_cyc - acc_cyc), 128'(1));
    checkOutput("t5_ndone", 128'(done_n - dn), 128'(0));

    // Stride burst: bank-hopping when enabled, unit increment otherwise.
    rb = req_n; ob = out_n; dn = done_n;
    applyStimulus(15'h0000, 12'd3, 15'h0400);
    waitDone("t6", 100);
    repeat (3) @(negedge clk);
`ifdef IBUF_RD_STRIDE_EN
    exp_a[0] = 15'h0000; exp_a[1] = 15'h0400; exp_a[2] = 15'h0800; exp_a[3] = 15'h0C00;
`else
    exp_a[0] = 15'h0000; exp_a[1] = 15'h0001; exp_a[2] = 15'h0002; exp_a[3] = 15'h0003;
`endif
    checkBurst("t6", rb, ob, 4);
    checkOutput("t6_ndone", 128'(done_n - dn), 128'(1));

    // Reset mid-burst, then a clean burst.
    applyStimulus(15'h0200, 12'd7, 15'd0);
    repeat (3) @(negedge clk);
    dn = done_n;
    rst_n = 1'b0;
    #1;
    checkOutput("t7_cen", 128'(ib_cen), 128'(0));
    checkOutput("t7_last", 128'(ib_last), 128'(0));
    checkOutput("t7_addr", 128'(ib_addr), 128'(0));
    checkOutput("t7_busy", 128'(busy), 128'(0));
    checkOutput("t7_done", 128'(done), 128'(0));
    checkOutput("t7_err", 128'(err), 128'(0));
    checkOutput("t7_cmdrdy", 128'(cmd_ready), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t7_no_done", 128'(done_n - dn), 128'(0));
    rb = req_n; ob = out_n; dn = done_n;
    applyStimulus(15'h0010, 12'd1, 15'd0);
    waitDone("t7b", 100);
    repeat (3) @(negedge clk);
    exp_a[0] = 15'h0010; exp_a[1] = 15'h0011;
    checkBurst("t7b", rb, ob, 2);
    checkOutput("t7b_ndone", 128'(done_n - dn), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
